// File: rtl/char_move_ctrl.sv
// char_move_ctrl: owns the player position and issues one collision query per movement step.
// It waits out the detector read latency, then commits or discards the 1 px move. It also
// times the sword attack window.
// Optional feature macro: KNOCKBACK_EN (an enemy hit pushes the player 4 px backwards).
module char_move_ctrl #(
   parameter logic [8:0]  START_X       = 9'd120,
   parameter logic [7:0]  START_Y       = 8'd80,
   parameter int unsigned MOVE_DIV      = 2,
   parameter int unsigned ATTACK_FRAMES = 8,
   parameter int unsigned QUERY_WAIT    = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_attack,
   input  logic       c_map_collision,
   input  logic       c_e1_collision,
   output logic       collision_enable,
   output logic [2:0] direction_char,
   output logic [2:0] facing_char,
   output logic       attack,
   output logic [8:0] char_x,
   output logic [7:0] char_y,
   output logic       busy
);

   typedef enum logic [2:0] {StIdle, StDecide, StQuery, StCommit, StAttack} state_e;

   localparam logic [2:0] DirNone  = 3'b000;
   localparam logic [2:0] DirUp    = 3'b010;
   localparam logic [2:0] DirDown  = 3'b011;
   localparam logic [2:0] DirLeft  = 3'b100;
   localparam logic [2:0] DirRight = 3'b101;

   localparam logic [4:0] MoveDiv   = 5'(MOVE_DIV);
   localparam logic [7:0] AtkFrames = 8'(ATTACK_FRAMES);
   localparam logic [2:0] QueryLast = 3'(QUERY_WAIT);

   state_e     state_q, state_d;
   logic       pending_q, pending_d;
   logic [3:0] step_cnt_q, step_cnt_d;
   logic [7:0] atk_cnt_q, atk_cnt_d;
   logic [2:0] wait_cnt_q, wait_cnt_d;
   logic       hit_q, hit_d;
   logic       e1_q, e1_d;
   logic [2:0] dir_q, dir_d;
   logic [2:0] facing_q, facing_d;
   logic       attack_q, attack_d;
   logic [8:0] char_x_q, char_x_d;
   logic [7:0] char_y_q, char_y_d;

   logic [4:0]        step_next;
   logic [2:0]        btn_dir;
   logic              knock;
   logic signed [10:0] dx, dy, sum_x, sum_y;
   logic [8:0]        clamp_x;
   logic [7:0]        clamp_y;

`ifdef KNOCKBACK_EN
   assign knock = e1_q;
`else
   // Enemy result has no effect in this build.
   logic unused_e1;
   assign unused_e1 = c_e1_collision;
   assign knock     = 1'b0;
`endif

   // Button priority: UP > DOWN > LEFT > RIGHT.
   always_comb begin
      btn_dir = DirNone;
      if (btn_up)         btn_dir = DirUp;
      else if (btn_down)  btn_dir = DirDown;
      else if (btn_left)  btn_dir = DirLeft;
      else if (btn_right) btn_dir = DirRight;
   end

   // Candidate position for COMMIT: signed, wider than the position, then clamped.
   always_comb begin
      dx = 11'sd0;
      dy = 11'sd0;
      if (knock) begin
         case (facing_q)
            DirUp:    dy = 11'sd4;
            DirDown:  dy = -11'sd4;
            DirLeft:  dx = 11'sd4;
            DirRight: dx = -11'sd4;
            default:  ;
         endcase
      end else if (!hit_q) begin
         case (dir_q)
            DirUp:    dy = -11'sd1;
            DirDown:  dy = 11'sd1;
            DirLeft:  dx = -11'sd1;
            DirRight: dx = 11'sd1;
            default:  ;
         endcase
      end
      sum_x = $signed({2'b00, char_x_q}) + dx;
      sum_y = $signed({3'b000, char_y_q}) + dy;
      if (sum_x < 11'sd0)        clamp_x = 9'd0;
      else if (sum_x > 11'sd240) clamp_x = 9'd240;
      else                       clamp_x = sum_x[8:0];
      if (sum_y < 11'sd0)        clamp_y = 8'd0;
      else if (sum_y > 11'sd160) clamp_y = 8'd160;
      else                       clamp_y = sum_y[7:0];
   end

   // Next-state logic for the movement/attack sequencer.
   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      step_cnt_d = step_cnt_q;
      atk_cnt_d  = atk_cnt_q;
      wait_cnt_d = wait_cnt_q;
      hit_d      = hit_q;
      e1_d       = e1_q;
      dir_d      = dir_q;
      facing_d   = facing_q;
      attack_d   = attack_q;
      char_x_d   = char_x_q;
      char_y_d   = char_y_q;
      step_next  = {1'b0, step_cnt_q} + 5'd1;

      // One-deep tick memory; ATTACK consumes its own ticks.
      if (frame_tick && (state_q == StDecide || state_q == StQuery || state_q == StCommit)) begin
         pending_d = 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (frame_tick || pending_q) begin
               state_d   = StDecide;
               pending_d = 1'b0;
            end
         end
         StDecide: begin
            if (btn_attack) begin
               state_d   = StAttack;
               atk_cnt_d = AtkFrames;
               attack_d  = 1'b1;
            end else if (step_next < MoveDiv) begin
               step_cnt_d = step_next[3:0];
               state_d    = StIdle;
            end else begin
               step_cnt_d = 4'd0;
               if (btn_dir == DirNone) begin
                  state_d = StIdle;
               end else begin
                  dir_d      = btn_dir;
                  facing_d   = btn_dir;
                  wait_cnt_d = 3'd0;
                  state_d    = StQuery;
               end
            end
         end
         StQuery: begin
            if (wait_cnt_q == QueryLast) begin
               hit_d   = c_map_collision;
               e1_d    = c_e1_collision;
               state_d = StCommit;
            end else begin
               wait_cnt_d = wait_cnt_q + 3'd1;
            end
         end
         StCommit: begin
            char_x_d = clamp_x;
            char_y_d = clamp_y;
            dir_d    = DirNone;
            state_d  = StIdle;
         end
         StAttack: begin
            if (frame_tick) begin
               if (atk_cnt_q <= 8'd1) begin
                  atk_cnt_d = 8'd0;
                  attack_d  = 1'b0;
                  state_d   = StIdle;
               end else begin
                  atk_cnt_d = atk_cnt_q - 8'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         pending_q  <= 1'b0;
         step_cnt_q <= 4'd0;
         atk_cnt_q  <= 8'd0;
         wait_cnt_q <= 3'd0;
         hit_q      <= 1'b0;
         e1_q       <= 1'b0;
         dir_q      <= DirNone;
         facing_q   <= DirDown;
         attack_q   <= 1'b0;
         char_x_q   <= START_X;
         char_y_q   <= START_Y;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         step_cnt_q <= step_cnt_d;
         atk_cnt_q  <= atk_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         hit_q      <= hit_d;
         e1_q       <= e1_d;
         dir_q      <= dir_d;
         facing_q   <= facing_d;
         attack_q   <= attack_d;
         char_x_q   <= char_x_d;
         char_y_q   <= char_y_d;
      end
   end

   assign collision_enable = (state_q == StQuery);
   assign busy             = (state_q != StIdle);
   assign direction_char   = dir_q;
   assign facing_char      = facing_q;
   assign attack           = attack_q;
   assign char_x           = char_x_q;
   assign char_y           = char_y_q;

endmodule

// File: tb/tb_char_move_ctrl.sv
// tb_char_move_ctrl: directed and random frame-tick sequences against a per-tick behavioural
// model of position, facing, step division, attack window and query strobe length.
// Knockback checks run only when KNOCKBACK_EN is defined.
module tb_char_move_ctrl;

   localparam int MOVE_DIV      = 2;
   localparam int ATTACK_FRAMES = 8;
   localparam int QUERY_WAIT    = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic       btn_up, btn_down, btn_left, btn_right, btn_attack;
   logic       c_map_collision, c_e1_collision;
   logic       collision_enable;
   logic [2:0] direction_char;
   logic [2:0] facing_char;
   logic       attack;
   logic [8:0] char_x;
   logic [7:0] char_y;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state.
   int m_x, m_y, m_face, m_step, m_atk;

   char_move_ctrl #(
      .START_X      (9'd120),
      .START_Y      (8'd80),
      .MOVE_DIV     (MOVE_DIV),
      .ATTACK_FRAMES(ATTACK_FRAMES),
      .QUERY_WAIT   (QUERY_WAIT)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .frame_tick      (frame_tick),
      .btn_up          (btn_up),
      .btn_down        (btn_down),
      .btn_left        (btn_left),
      .btn_right       (btn_right),
      .btn_attack      (btn_attack),
      .c_map_collision (c_map_collision),
      .c_e1_collision  (c_e1_collision),
      .collision_enable(collision_enable),
      .direction_char  (direction_char),
      .facing_char     (facing_char),
      .attack          (attack),
      .char_x          (char_x),
      .char_y          (char_y),
      .busy            (busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_x = 120; m_y = 80; m_face = 3; m_step = 0; m_atk = 0;
   endtask

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   // One frame tick with the given inputs held; model advanced and outputs compared afterwards.
   task automatic tick(input bit up, input bit dn, input bit lf, input bit rt, input bit atk,
                       input bit map, input bit e1);
      int en_cnt, exp_en, exp_dir, dir_seen;
      bit kb;
      @(negedge clock);
      btn_up = up; btn_down = dn; btn_left = lf; btn_right = rt; btn_attack = atk;
      c_map_collision = map; c_e1_collision = e1;
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      en_cnt = 0; dir_seen = 0;
      repeat (11) begin
         @(negedge clock);
         if (collision_enable === 1'b1) begin
            en_cnt++;
            dir_seen = int'(direction_char);
         end
      end
      exp_en = 0; exp_dir = 0;
      if (m_atk > 0) begin
         m_atk--;
      end else if (atk) begin
         m_atk = ATTACK_FRAMES;
      end else begin
         m_step++;
         if (m_step == MOVE_DIV) begin
            m_step = 0;
            exp_dir = up ? 2 : dn ? 3 : lf ? 4 : rt ? 5 : 0;
            if (exp_dir != 0) begin
               m_face = exp_dir;
               exp_en = QUERY_WAIT + 1;
               kb = 1'b0;
`ifdef KNOCKBACK_EN
               kb = e1;
`endif
               if (kb) begin
                  case (m_face)
                     2: m_y = m_y + 4;
                     3: m_y = m_y - 4;
                     4: m_x = m_x + 4;
                     default: m_x = m_x - 4;
                  endcase
               end else if (!map) begin
                  case (exp_dir)
                     2: m_y = m_y - 1;
                     3: m_y = m_y + 1;
                     4: m_x = m_x - 1;
                     default: m_x = m_x + 1;
                  endcase
               end
               m_x = clampi(m_x, 240);
               m_y = clampi(m_y, 160);
            end
         end
      end
      chk("char_x", 32'(char_x), m_x);
      chk("char_y", 32'(char_y), m_y);
      chk("facing_char", 32'(facing_char), m_face);
      chk("attack", 32'(attack), (m_atk > 0) ? 1 : 0);
      chk("busy", 32'(busy), (m_atk > 0) ? 1 : 0);
      chk("enable_cycles", en_cnt, exp_en);
      chk("direction_idle", 32'(direction_char), 0);
      if (exp_en > 0) chk("direction_query", dir_seen, exp_dir);
   endtask

   initial begin
      int x_saved;
      reset = 1'b1; frame_tick = 1'b0;
      btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_attack = 0;
      c_map_collision = 0; c_e1_collision = 0;
      m_reset();
      #1;
      chk("rst_char_x", 32'(char_x), 120);
      chk("rst_char_y", 32'(char_y), 80);
      chk("rst_facing", 32'(facing_char), 3);
      chk("rst_dir", 32'(direction_char), 0);
      chk("rst_enable", 32'(collision_enable), 0);
      chk("rst_attack", 32'(attack), 0);
      chk("rst_busy", 32'(busy), 0);
      repeat (3) @(negedge clock);
      reset = 1'b0;

      // Get into a query with the position moved, then reset mid-query.
      tick(0, 0, 0, 1, 0, 0, 0);
      tick(0, 0, 0, 1, 0, 0, 0);
      tick(0, 0, 0, 1, 0, 0, 0);
      @(negedge clock);
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      for (int i = 0; i < 10 && collision_enable !== 1'b1; i++) @(negedge clock);
      chk("query_reached", 32'(collision_enable), 1);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("midq_char_x", 32'(char_x), 120);
      chk("midq_char_y", 32'(char_y), 80);
      chk("midq_enable", 32'(collision_enable), 0);
      chk("midq_busy", 32'(busy), 0);
      chk("midq_facing", 32'(facing_char), 3);
      @(negedge clock);
      reset = 1'b0;
      m_reset();

      // Four ticks of right: two steps.
      repeat (4) tick(0, 0, 0, 1, 0, 0, 0);
      chk("right_x122", 32'(char_x), 122);
      chk("right_facing", 32'(facing_char), 3'b101);

      // Up+left together: only y moves.
      repeat (2) tick(1, 0, 1, 0, 0, 0, 0);
      chk("upleft_x", 32'(char_x), 122);
      chk("upleft_y", 32'(char_y), 79);

      // Top edge saturation.
      for (int i = 0; i < 400 && m_y > 0; i++) tick(1, 0, 0, 0, 0, 0, 0);
      repeat (2) tick(1, 0, 0, 0, 0, 0, 0);
      chk("y_floor", 32'(char_y), 0);

      // Map collision blocks the move.
      for (int i = 0; i < 40 && m_y < 5; i++) tick(0, 1, 0, 0, 0, 0, 0);
      repeat (2) tick(1, 0, 0, 0, 0, 1, 0);
      chk("y_blocked", 32'(char_y), 5);

      // Attack window: 8 ticks, buttons ignored, then stepping resumes.
      x_saved = m_x;
      tick(0, 0, 0, 0, 1, 0, 0);
      repeat (ATTACK_FRAMES) tick(0, 0, 0, 1, 0, 0, 0);
      chk("attack_x_frozen", 32'(char_x), x_saved);
      chk("attack_done", 32'(attack), 0);
      repeat (2) tick(0, 0, 0, 1, 0, 0, 0);
      chk("resume_x", 32'(char_x), x_saved + 1);

      // Right edge saturation.
      for (int i = 0; i < 600 && m_x < 240; i++) tick(0, 0, 0, 1, 0, 0, 0);
      repeat (2) tick(0, 0, 0, 1, 0, 0, 0);
      chk("x_ceiling", 32'(char_x), 240);

`ifdef KNOCKBACK_EN
      for (int i = 0; i < 600 && m_x > 100; i++) tick(0, 0, 1, 0, 0, 0, 0);
      repeat (2) tick(0, 0, 0, 1, 0, 0, 1);
      chk("kb_96", 32'(char_x), 96);
      chk("kb_facing", 32'(facing_char), 3'b101);
      for (int i = 0; i < 600 && m_x > 2; i++) tick(0, 0, 1, 0, 0, 0, 0);
      repeat (2) tick(0, 0, 0, 1, 0, 0, 1);
      chk("kb_0", 32'(char_x), 0);
`endif

      // Random buttons, collisions and occasional attacks.
      for (int i = 0; i < 200; i++) begin
         logic [3:0] b;
         b = 4'($urandom);
         tick(b[0], b[1], b[2], b[3], ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
